// File: rtl/buffer_pkg.sv
// Shared types and constants for the push/pop buffer read-side logic.
package buffer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } drain_state_t;

   localparam int DRAIN_SKID_MAX = 16;

   // Bits needed to hold an occupancy value of 0..depth inclusive.
   function automatic int occ_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/drain_skid.sv
// Small synchronous FIFO with first-word-fall-through output; holds the items
// already popped from the buffer until the stream sink accepts them.
module drain_skid
   import buffer_pkg::*;
#(
   parameter int  DATA_WIDTH = 8,
   parameter int  SKID_DEPTH = 2,
   localparam int CW         = occ_width(SKID_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic [CW-1:0]         count,
   output logic                  full,
   output logic                  empty
);

   localparam int              PW       = $clog2(SKID_DEPTH);
   localparam logic [CW-1:0]   DEPTH_V  = CW'(SKID_DEPTH);
   localparam logic [PW-1:0]   LAST_PTR = PW'(SKID_DEPTH - 1);

   logic [DATA_WIDTH-1:0] mem_r [SKID_DEPTH];
   logic [PW-1:0]         wr_ptr_r;
   logic [PW-1:0]         rd_ptr_r;
   logic [CW-1:0]         count_r;
   logic                  do_wr_s;
   logic                  do_rd_s;

   // Pointers wrap explicitly so non-power-of-two depths work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
      if (ptr == LAST_PTR) begin
         return {PW{1'b0}};
      end else begin
         return ptr + PW'(1);
      end
   endfunction

   // Status flags, accepted read/write strobes and fall-through read data.
   always_comb begin
      count   = count_r;
      full    = (count_r == DEPTH_V);
      empty   = (count_r == {CW{1'b0}});
      do_rd_s = rd_en & ~empty;
      // A write into a full FIFO is accepted only when a read frees a slot.
      do_wr_s = wr_en & (~full | do_rd_s);
      rd_data = {DATA_WIDTH{1'b0}};
      if (empty) begin
         rd_data = {DATA_WIDTH{1'b0}};
      end else begin
         rd_data = mem_r[rd_ptr_r];
      end
   end

   // Storage, pointers and occupancy.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
         for (int i = 0; i < SKID_DEPTH; i++) begin
            mem_r[i] <= {DATA_WIDTH{1'b0}};
         end
      end else begin
         if (do_wr_s) begin
            mem_r[wr_ptr_r] <= wr_data;
            wr_ptr_r        <= ptr_inc(wr_ptr_r);
         end
         if (do_rd_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         case ({do_wr_s, do_rd_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/buffer_drain.sv
// Read-side master for the push/pop buffer: pops it, captures the registered
// read data and re-presents it as a valid/ready stream. Optional pop counter
// is built when BUFFER_DRAIN_STATS_EN is defined.
module buffer_drain
   import buffer_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int SKID_DEPTH = 2,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   output logic                  buf_pop_en,
   output logic                  buf_pop,
   input  logic [DATA_WIDTH-1:0] buf_data,
   input  logic                  buf_is_empty,
   input  logic                  buf_err,
   input  logic                  push_busy,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  idle,
   output logic                  err_seen,
   output logic [CNT_WIDTH-1:0]  pop_count
);

   // Out-of-range depths are clamped to the legal 2..DRAIN_SKID_MAX window.
   localparam int DEPTH_EFF = (SKID_DEPTH > DRAIN_SKID_MAX) ? DRAIN_SKID_MAX :
                              ((SKID_DEPTH < 2) ? 2 : SKID_DEPTH);
   localparam int CW = occ_width(DEPTH_EFF);
   localparam logic [CW:0] SKID_LIMIT = (CW + 1)'(DEPTH_EFF);

   drain_state_t    state_r;
   drain_state_t    next_state_s;
   logic            inflight_r;
   logic            err_seen_r;
   logic [CW-1:0]   skid_count_s;
   logic            skid_full_s;
   logic            skid_empty_s;
   logic            xfer_s;
   logic [CW:0]     credit_s;
   logic            pop_s;
   logic            err_event_s;

   drain_skid #(
      .DATA_WIDTH (DATA_WIDTH),
      .SKID_DEPTH (DEPTH_EFF)
   ) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (inflight_r),
      .wr_data (buf_data),
      .rd_en   (m_ready),
      .rd_data (m_data),
      .count   (skid_count_s),
      .full    (skid_full_s),
      .empty   (skid_empty_s)
   );

   // Pop decision: never pop into a slot that might not be free when the
   // data arrives, counting the item already in flight and the one leaving.
   always_comb begin
      xfer_s   = ~skid_empty_s & m_ready;
      credit_s = {1'b0, skid_count_s} + {{CW{1'b0}}, inflight_r}
                 - {{CW{1'b0}}, xfer_s};
      pop_s    = (state_r == RUN) & ~buf_is_empty & ~push_busy
                 & (credit_s < SKID_LIMIT);
      err_event_s = inflight_r & (buf_err | (skid_full_s & ~xfer_s));
   end

   // Next-state logic.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (enable) next_state_s = RUN;
            else        next_state_s = IDLE;
         end
         RUN: begin
            if (!enable) next_state_s = STOP;
            else         next_state_s = RUN;
         end
         STOP: begin
            if (!inflight_r) next_state_s = IDLE;
            else             next_state_s = STOP;
         end
         default: next_state_s = IDLE;
      endcase
   end

   // State, in-flight marker and sticky error flag.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_r    <= IDLE;
         inflight_r <= 1'b0;
         err_seen_r <= 1'b0;
      end else begin
         state_r    <= next_state_s;
         inflight_r <= pop_s;
         if (err_event_s) begin
            err_seen_r <= 1'b1;
         end
      end
   end

   assign buf_pop    = pop_s;
   assign buf_pop_en = (state_r == RUN);
   assign m_valid    = ~skid_empty_s;
   assign idle       = (state_r == IDLE) & skid_empty_s;
   assign err_seen   = err_seen_r;

`ifdef BUFFER_DRAIN_STATS_EN
   logic [CNT_WIDTH-1:0] pop_count_r;

   // Free-running pop counter, wraps naturally.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         pop_count_r <= {CNT_WIDTH{1'b0}};
      end else if (pop_s) begin
         pop_count_r <= pop_count_r + CNT_WIDTH'(1);
      end
   end

   assign pop_count = pop_count_r;
`else
   assign pop_count = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_buffer_drain.sv
// Directed bench for buffer_drain with a behavioural push/pop buffer model
// and a scoreboard of expected stream items.
module tb_buffer_drain;
   import buffer_pkg::*;

   localparam int DW   = 8;
   localparam int SD   = 2;
   localparam int CNTW = 4;

   logic            clk          = 1'b0;
   logic            rst_n        = 1'b1;
   logic            enable       = 1'b0;
   logic            buf_pop_en;
   logic            buf_pop;
   logic [DW-1:0]   buf_data     = '0;
   logic            buf_is_empty = 1'b1;
   logic            buf_err      = 1'b0;
   logic            push_busy    = 1'b0;
   logic            m_valid;
   logic            m_ready      = 1'b0;
   logic [DW-1:0]   m_data;
   logic            idle;
   logic            err_seen;
   logic [CNTW-1:0] pop_count;

   int              nchecks      = 0;
   int              nerrors      = 0;
   int              cyc          = 0;
   int              pops_seen    = 0;
   bit              buf_err_seen = 1'b0;
   bit              filo         = 1'b0;
   logic [DW-1:0]   push_val     = '0;
   logic [DW-1:0]   bq[$];
   logic [DW-1:0]   sb[$];
   int              xfer_cyc[$];
   bit              prev_stall   = 1'b0;
   logic [DW-1:0]   prev_data    = '0;
   int              p0;
   int              en_cyc;

   always #5 clk = ~clk;

   buffer_drain #(
      .DATA_WIDTH (DW),
      .SKID_DEPTH (SD),
      .CNT_WIDTH  (CNTW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .buf_pop_en   (buf_pop_en),
      .buf_pop      (buf_pop),
      .buf_data     (buf_data),
      .buf_is_empty (buf_is_empty),
      .buf_err      (buf_err),
      .push_busy    (push_busy),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .idle         (idle),
      .err_seen     (err_seen),
      .pop_count    (pop_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchecks++;
      assert (obs === exp) else begin
         nerrors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Buffer model: registered data_out and err, FIFO or FILO order.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (buf_pop) begin
         if (!buf_pop_en || bq.size() == 0 || push_busy) begin
            buf_err <= 1'b1;
         end else begin
            buf_err <= 1'b0;
            if (filo) buf_data <= bq.pop_back();
            else      buf_data <= bq.pop_front();
         end
      end else begin
         buf_err <= 1'b0;
      end
      if (push_busy) bq.push_back(push_val);
      buf_is_empty <= (bq.size() == 0);
   end

   // Stream monitor: scoreboard compare, hold rule, pop/push exclusion.
   always @(negedge clk) begin
      if (rst_n) begin
         prev_stall <= 1'b0;
      end else begin
         if (buf_pop) pops_seen <= pops_seen + 1;
         if (push_busy) check("pop_during_push", 32'(buf_pop), 32'd0);
         if (buf_err) buf_err_seen <= 1'b1;
         if (prev_stall) begin
            check("hold_valid", 32'(m_valid), 32'd1);
            check("hold_data", 32'(m_data), 32'(prev_data));
         end
         if (m_valid && m_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_item", 32'(m_data), 32'h100);
            end else begin
               check("stream_data", 32'(m_data), 32'(sb.pop_front()));
               xfer_cyc.push_back(cyc);
            end
         end
         prev_stall <= m_valid & ~m_ready;
         prev_data  <= m_data;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [DW-1:0] v, input bit exp);
      bq.push_back(v);
      if (exp) sb.push_back(v);
   endtask

   task automatic wait_drain(input string tag, input int max);
      for (int i = 0; i < max; i++) begin
         if (sb.size() == 0) break;
         tick();
      end
      check(tag, 32'(sb.size()), 32'd0);
   endtask

   task automatic stop_run(input string tag);
      enable = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (idle && dut.state_r == IDLE) break;
         tick();
      end
      check(tag, 32'(idle), 32'd1);
   endtask

   initial begin
      // Reset values while reset is held.
      repeat (3) tick();
      check("rst_pop_en", 32'(buf_pop_en), 32'd0);
      check("rst_pop", 32'(buf_pop), 32'd0);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_m_data", 32'(m_data), 32'd0);
      check("rst_idle", 32'(idle), 32'd1);
      check("rst_err_seen", 32'(err_seen), 32'd0);
      check("rst_pop_count", 32'(pop_count), 32'd0);
      rst_n = 1'b0;
      tick();

      // FIFO buffer 1..5, sink always ready: back-to-back stream.
      for (int v = 1; v <= 5; v++) load(8'(v), 1'b1);
      tick();
      p0 = pops_seen;
      xfer_cyc.delete();
      m_ready = 1'b1;
      enable  = 1'b1;
      en_cyc  = cyc;
      wait_drain("t1_drain", 30);
      check("t1_pops", 32'(pops_seen - p0), 32'd5);
      check("t1_xfers", 32'(xfer_cyc.size()), 32'd5);
      check("t1_first_cycle", 32'(xfer_cyc[0]), 32'(en_cyc + 3));
      check("t1_last_cycle", 32'(xfer_cyc[4]), 32'(en_cyc + 7));
      stop_run("t1_idle");

      // FILO buffer 1..4 streams out reversed.
      filo = 1'b1;
      for (int v = 1; v <= 4; v++) load(8'(v), 1'b0);
      for (int v = 4; v >= 1; v--) sb.push_back(8'(v));
      tick();
      enable = 1'b1;
      wait_drain("t2_drain", 30);
      stop_run("t2_idle");
      filo = 1'b0;

      // Sink stalled: only SKID_DEPTH pops, then everything arrives.
      m_ready = 1'b0;
      for (int v = 51; v <= 56; v++) load(8'(v), 1'b1);
      tick();
      p0 = pops_seen;
      enable = 1'b1;
      repeat (8) tick();
      check("t3_stall_pops", 32'(pops_seen - p0), 32'd2);
      check("t3_stall_nopop", 32'(buf_pop), 32'd0);
      check("t3_stall_valid", 32'(m_valid), 32'd1);
      check("t3_stall_data", 32'(m_data), 32'd51);
      m_ready = 1'b1;
      wait_drain("t3_drain", 40);
      check("t3_total_pops", 32'(pops_seen - p0), 32'd6);
      stop_run("t3_idle");

      // Writer pushing every other cycle while draining.
      for (int v = 31; v <= 34; v++) load(8'(v), 1'b1);
      tick();
      enable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         push_busy = (i % 2 == 1);
         if (push_busy) begin
            push_val = 8'(40 + i);
            sb.push_back(push_val);
         end
         tick();
      end
      push_busy = 1'b0;
      wait_drain("t4_drain", 40);
      stop_run("t4_idle");
      check("t4_err_seen", 32'(err_seen), 32'd0);
      check("t4_buf_err", 32'(buf_err_seen), 32'd0);

      // Enable dropped in the cycle of a pop: item still delivered.
      load(8'd21, 1'b1);
      load(8'd22, 1'b0);
      load(8'd23, 1'b0);
      tick();
      p0 = pops_seen;
      enable = 1'b1;
      tick();
      check("t5_pop", 32'(buf_pop), 32'd1);
      enable = 1'b0;
      tick();
      check("t5_stop", 32'(dut.state_r), 32'(STOP));
      check("t5_pop_en", 32'(buf_pop_en), 32'd0);
      for (int i = 0; i < 5; i++) begin
         if (dut.state_r == IDLE) break;
         tick();
      end
      check("t5_idle_state", 32'(dut.state_r), 32'(IDLE));
      wait_drain("t5_drain", 10);
      repeat (3) tick();
      check("t5_pops", 32'(pops_seen - p0), 32'd1);
      check("t5_idle", 32'(idle), 32'd1);
      bq.delete();
      tick();

      // Reset mid-operation discards skid and in-flight data.
      m_ready = 1'b0;
      for (int v = 61; v <= 64; v++) load(8'(v), 1'b0);
      tick();
      enable = 1'b1;
      repeat (5) tick();
      rst_n = 1'b1;
      #1;
      check("mid_rst_valid", 32'(m_valid), 32'd0);
      check("mid_rst_data", 32'(m_data), 32'd0);
      check("mid_rst_idle", 32'(idle), 32'd1);
      check("mid_rst_pop_en", 32'(buf_pop_en), 32'd0);
      check("mid_rst_pop_count", 32'(pop_count), 32'd0);
      enable = 1'b0;
      bq.delete();
      tick();
      tick();
      rst_n = 1'b0;
      tick();

      // 17 pops: counter wraps at 2^CNT_WIDTH when built.
      for (int v = 0; v < 17; v++) load(8'(70 + v), 1'b1);
      m_ready = 1'b1;
      tick();
      enable = 1'b1;
      wait_drain("t6_drain", 60);
      stop_run("t6_idle");
`ifdef BUFFER_DRAIN_STATS_EN
      check("t6_pop_count", 32'(pop_count), 32'd1);
`else
      check("t6_pop_count", 32'(pop_count), 32'd0);
`endif
      check("final_err_seen", 32'(err_seen), 32'd0);
      check("final_buf_err", 32'(buf_err_seen), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule

// File: doc/buffer_drain.md
# buffer_drain

Read-side master for the push/pop buffer: drives the buffer's pop port, captures its registered read data, and re-presents it as a valid/ready stream to a downstream consumer. It sits between a `buffer_tmp` instance (FIFO or FILO order) and any streaming sink. It never issues a pop that the buffer would flag as an error: no pop while empty, no pop without enable, no pop coincident with a push.

## Interface
- `DATA_WIDTH`, 8, width of buffer data and stream data.
- `SKID_DEPTH`, 2, output holding slots; legal range 2..16.
- `CNT_WIDTH`, 16, width of the pop statistics counter.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-high.
- `enable`  in  1  run request from control.
- `buf_pop_en`  out  1  to buffer `pop_en`.
- `buf_pop`  out  1  to buffer `pop`.
- `buf_data`  in  DATA_WIDTH  from buffer `data_out`.
- `buf_is_empty`  in  1  from buffer `is_empty`.
- `buf_err`  in  1  from buffer `err`.
- `push_busy`  in  1  the writer is asserting push this cycle.
- `m_valid`  out  1  stream data valid.
- `m_ready`  in  1  sink accepts.
- `m_data`  out  DATA_WIDTH  stream data.
- `idle`  out  1  FSM in IDLE and skid empty.
- `err_seen`  out  1  sticky; buffer `err` was seen in the cycle after a pop of ours.
- `pop_count`  out  CNT_WIDTH  number of pops issued (only with the macro).

## Operation
- FSM states: IDLE, RUN, STOP.
  - IDLE → RUN when `enable` is high.
  - RUN → STOP when `enable` is low.
  - STOP → IDLE once no pop is in flight, i.e. the cycle after the last pop.
- `buf_pop_en` is 1 in RUN only.
- `buf_pop` is combinational and is 1 only when all of the following hold:
  - state is RUN
  - `buf_is_empty` is 0
  - `push_busy` is 0
  - `skid_count + inflight − (m_valid & m_ready) < SKID_DEPTH`
- `inflight` is a register equal to the previous cycle's `buf_pop`.
- When `inflight` is 1, `buf_data` is written into the skid FIFO at the same edge.
- The skid FIFO presents data in arrival order, so downstream order equals buffer pop order (FIFO or FILO as built).
- The credit rule guarantees the skid never overflows. If a write to a full skid is ever attempted, the data is dropped and `err_seen` is set.
- `err_seen` is set when `buf_err` is 1 and `inflight` is 1. It is cleared only by reset.
- Sink handshake:
  - `m_data` is held stable while `m_valid & ~m_ready`.
  - A transfer occurs when `m_valid & m_ready` at the edge.
  - A simultaneous skid write and read on a full skid is legal.
- When `enable` drops mid-stream, the in-flight item is still captured. Skid contents keep draining to the sink in STOP and IDLE; `idle` waits for that.

## Timing
- Reset values:
  - state IDLE, `inflight` 0, skid empty
  - `buf_pop_en` 0, `buf_pop` 0
  - `m_valid` 0, `m_data` 0
  - `idle` 1, `err_seen` 0, `pop_count` 0
- Latency:
  - `buf_pop` in cycle N → data captured at the end of N+1 → `m_valid` in N+2.
  - `enable` rise → first possible pop 1 cycle later (IDLE→RUN transition).
- Throughput: 1 item per cycle with `m_ready` held high, `SKID_DEPTH` ≥ 2 and a non-empty buffer.
- `buf_is_empty` is treated as current in the cycle after a pop; no extra pop guard is needed.
- Reset mid-operation: all state clears immediately, and skid contents and the in-flight item are discarded.

## Configuration
- `BUFFER_DRAIN_STATS_EN` defined:
  - `pop_count` increments on every cycle with `buf_pop` high.
  - It wraps modulo 2^CNT_WIDTH.
- Undefined:
  - The counter is not built and `pop_count` is tied to 0.
  - All other behaviour is identical.

## Structure
- Package `buffer_pkg` holds:
  - `drain_state_t` enum (IDLE, RUN, STOP)
  - constant `DRAIN_SKID_MAX = 16`
- Sub-module `drain_skid`: a parameterised synchronous FIFO (DATA_WIDTH, SKID_DEPTH) providing `count`, `full` and `empty`, with first-word-fall-through output.
- The FSM, credit logic, error monitor and counter live in the top module.

## Test plan
- Preload the FIFO-ordered buffer with 1..5, hold `m_ready`=1, raise `enable` → pops in 5 consecutive cycles; `m_data` 1..5 on consecutive cycles starting 3 cycles after `enable`; `idle`=1 after `enable` drops.
- Preload the FILO-ordered buffer with 1..4 → stream order 4,3,2,1.
- `m_ready`=0 with buffer holding 6 and `SKID_DEPTH`=2 → exactly 2 pops, then `buf_pop` stays 0; releasing `m_ready` resumes and all 6 items arrive with none lost.
- `push_busy` pulsed high every other cycle → `buf_pop` never coincides with it; `err_seen` stays 0; buffer `err` stays 0.
- `enable` dropped in the same cycle as a pop → the item still appears on `m_data`; FSM goes STOP then IDLE; no further pops.
- With `BUFFER_DRAIN_STATS_EN`, `CNT_WIDTH`=4: 17 pops → `pop_count`=1. Without the macro → 0.
